serial_add_ctrl: RTL and testbench

- Bit-serial N-bit adder controller.
- Sequences one full-adder cell, built as two half adders plus an OR, over WIDTH cycles. Bit i is processed in cycle i, LSB first.
- A carry flip-flop and the operand/result shift registers are internal to this block.
- Used where area matters more than latency. It also demonstrates sequencing of the team's half-adder primitive.

---
 rtl/serial_add_ctrl.sv | 132 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell (two half adders + OR) stepped LSB first.
// Optional SERIAL_ADD_OVF_EN adds the registered signed-overflow output ovf.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_c_ff;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       w_ha1;
  logic [1:0]       w_ha2;
  logic             w_s;
  logic             w_c;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Returns {carry, sum} of a single-bit half adder.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  always_comb begin
    w_ha1      = half_add(r_a_sr[0], r_b_sr[0]);
    w_ha2      = half_add(w_ha1[0], r_c_ff);
    w_s        = w_ha2[0];
    w_c        = w_ha1[1] | w_ha2[1];
    w_res_next = {w_s, r_res_sr[WIDTH-1:1]};
  end

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = start ? S_RUN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture on accepted start, one bit per RUN edge, publish on the last bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_c_ff   <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
    end else if (w_accept) begin
      r_a_sr <= a;
      r_b_sr <= b;
      r_c_ff <= cin;
      r_cnt  <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_c_ff   <= w_c;
      r_res_sr <= w_res_next;
      if (w_last) begin
        r_cnt   <= '0;
        r_sum   <= w_res_next;
        r_carry <= w_c;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign sum   = r_sum;
  assign carry = r_carry;

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;

  // On the MSB step r_c_ff is the carry into the MSB and w_c the carry out of it.
  always_ff @(posedge clk) begin
    if (!rst_n)      r_ovf <= 1'b0;
    else if (w_last) r_ovf <= r_c_ff ^ w_c;
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: vector table plus hand-written abort / ignore / back-to-back sequences.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .carry(carry)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   pushed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      done_cnt++;
      check("busy_low_in_done", busy, 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("sum", sum, e.s);
        check("carry", carry, e.c);
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", ovf, e.v);
`endif
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] s, input logic c, input logic v);
    exp_t e;
    e.s = s;
    e.c = c;
    e.v = v;
    sb.push_back(e);
    pushed++;
  endtask

  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) nb++;
      tick();
      n++;
    end
    if (done !== 1'b1) check("done_timeout", done, 1);
  endtask

  task automatic run_op(input vec_t v, input string nm);
    int n, nb;
    a = v.a;
    b = v.b;
    cin = v.cin;
    start = 1'b1;
    push(v.s, v.c, v.v);
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    wait_done(n, nb);
    check({nm, "_latency"}, n, W);
    check({nm, "_busy_cycles"}, nb, W);
    tick();
    check({nm, "_done_one_cycle"}, done, 0);
  endtask

  function automatic vec_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    vec_t v;
    logic [W:0] t;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    v.a = x;
    v.b = y;
    v.cin = ci;
    v.s = t[W-1:0];
    v.c = t[W];
    v.v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int n, nb, c1, c2, d0;
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, nb, c1, c2, d0;
    //            a      b      cin   sum    carry ovf
    tbl.push_back('{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0});
    tbl.push_back('{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1});
    tbl.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1});
    tbl.push_back('{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0});
    tbl.push_back('{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0});
    for (int i = 0; i < 4; i++)
      tbl.push_back(model(W'($urandom), W'($urandom), 1'($urandom)));

    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 8'h00);
    check("rst_carry", carry, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < tbl.size(); i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // Second start during RUN must be ignored.
    d0 = done_cnt;
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    push(8'h46, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, nb);
    check("ignore_latency", n, W - 3);
    repeat (14) tick();
    check("ignore_single_done", done_cnt - d0, 1);

    // Reset mid-RUN aborts with no done and clears the result.
    d0 = done_cnt;
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 8'h00);
    check("abort_carry", carry, 0);
`ifdef SERIAL_ADD_OVF_EN
    check("abort_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    repeat (12) tick();
    check("abort_no_done", done_cnt - d0, 0);
    run_op('{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0}, "post_abort");

    // Back-to-back: start held, second operands accepted in the DONE cycle.
    a = 8'd1; b = 8'd2; cin = 1'b0; start = 1'b1;
    push(8'h03, 1'b0, 1'b0);
    tick();
    wait_done(n, nb);
    check("b2b_first_latency", n, W);
    c1 = cyc;
    a = 8'd3; b = 8'd4;
    push(8'h07, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    check("b2b_busy_after_done", busy, 1);
    wait_done(n, nb);
    c2 = cyc;
    check("b2b_done_spacing", c2 - c1, W + 1);
    repeat (3) tick();

    check("scoreboard_empty", sb.size(), 0);
    check("done_count", done_cnt, pushed);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
